throw_ctrl: RTL and testbench
=============================

# throw_ctrl

Turn and throw initiator for the cat-vs-dog game: converts the debounced throw button into the `throw_command` / `throw_power` handshake consumed by the player drawers and waits for the active drawer's `throw_complete` pulse. After the pulse it hands the turn to the other player. It sits upstream of the cat and dog drawers on the control side. It also sits in the VGA chain as a one-stage overlay that can draw a power bar.

## Interface
- POWER_STEP_CYCLES, 65_000, clock cycles per power step of ±1.
- TIMEOUT_CYCLES, 8_000_000, maximum wait in RELEASE before the turn is forced to switch. Must exceed 3_550_000, the worst-case drawer throw time.
- BAR_X, 384: left edge of the power bar, in pixels.
- BAR_Y, 40: top edge of the power bar, in pixels.
- BAR_H, 16: height of the power bar, in pixels.
- BAR_RGB, 12'hF40: colour of the filled part of the bar.
- BAR_BG_RGB, 12'h333: colour of the unfilled part of the bar.
- clk  in  1  system/pixel clock.
- rst  in  1  reset, synchronous and active-high.
- game_enable  in  1  game is running; when low, the block is held in IDLE.
- btn_throw  in  1  debounced throw button level, already synchronous to clk.
- throw_complete_cat  in  1  one-cycle pulse from the cat drawer.
- throw_complete_dog  in  1  one-cycle pulse from the dog drawer.
- turn_cat  out  1  registered; drives the cat drawer's turn_active.
- turn_dog  out  1  registered; drives the dog drawer's turn_active.
- throw_command  out  1  registered throw request.
- throw_power  out  8  registered power; stable from release until SWITCH.
- ctrl_state  out  3  current FSM state, for debug.
- vga_in  vga_if.vga_in  —  upstream VGA timing and rgb.
- vga_out  vga_if.vga_out  —  VGA stream delayed by one cycle.

## Operation
- FSM states:
  - IDLE=0: entered on reset or whenever game_enable=0 (checked in every state).
  - ARMED=1: game_enable=1 → ARMED. Leaves for READY when btn_throw=0, so a button still held from the last turn never starts a throw.
  - READY=2: btn_throw=1 → CHARGE. Power is cleared to 0 and the ramp direction is set to up.
  - CHARGE=3: throw_command=1 and the power ramps.
    - btn_throw=0 → RELEASE; power freezes.
  - RELEASE=4: throw_command=0; a wait counter starts from 0.
    - Active player's throw_complete → SWITCH.
    - Wait counter reaching TIMEOUT_CYCLES-1 → SWITCH.
  - SWITCH=5: one cycle. Toggles turn_sel, clears power, → ARMED.
- turn_sel register resets to 0 (cat). turn_cat = (state∈{ARMED..RELEASE}) ∧ turn_sel=0. turn_dog is the same with turn_sel=1.
- Power ramp (CHARGE only):
  - Prescaler counts 0..POWER_STEP_CYCLES-1. On the wrap, power steps by ±1.
  - Ping-pong: the step at 255 goes down to 254; the step at 0 goes up to 1. Power never wraps past 255 or below 0.
- Boundary conditions:
  - throw_complete from the non-active player is ignored. Either pulse is ignored outside RELEASE.
  - A release and a prescaler wrap in the same cycle: the release wins and power is not stepped.
  - game_enable dropping mid-CHARGE or mid-RELEASE: → IDLE next cycle, throw_command=0, power=0, turn_sel kept. A drawer still in THROW1/THROW2 finishes on its own, and its pulse is ignored.
  - rst at any point: every output returns to its reset value next edge.
- Reset values: turn_cat=0, turn_dog=0, throw_command=0, throw_power=0, ctrl_state=IDLE. The vga_out timing signals and rgb are 0.

## Timing
- All control outputs are registered. An input sampled at edge n is reflected on the outputs after edge n+1.
- btn_throw rising while in READY at cycle n: throw_command=1 from cycle n+1.
- btn_throw falling: throw_command=0 one cycle later, with throw_power frozen on the same cycle.
- Accepted throw_complete at cycle n: SWITCH at n+1, new turn outputs at n+2.
- VGA path: exactly one register stage. hcount, vcount, hsync, vsync, hblnk, vblnk and rgb are delayed together. Overlay rgb is selected combinationally from the delayed signals.

## Configuration
- THROW_CTRL_POWER_BAR_EN defined:
  - In CHARGE or RELEASE, pixels with BAR_X ≤ h < BAR_X+256 and BAR_Y ≤ v < BAR_Y+BAR_H, outside blanking, are overlaid.
  - The overlay is BAR_RGB where (h−BAR_X) < throw_power, else BAR_BG_RGB.
- Undefined: vga_out is vga_in delayed by one cycle with rgb unmodified. The latency is the same either way.

## Structure
- game_pkg holds:
  - the state typedef enum logic [2:0] {IDLE, ARMED, READY, CHARGE, RELEASE, SWITCH};
  - the PLAYER_CAT=0 and PLAYER_DOG=1 constants;
  - MAX_POWER=8'd255.
- Sub-module throw_power_ramp contains the prescaler and the ping-pong counter. Ports: clk, rst, clear, enable, power[7:0].
- The top level holds the FSM, the timeout counter, turn_sel and the VGA stage.

## Test plan
Bench uses POWER_STEP_CYCLES=4 and TIMEOUT_CYCLES=1000.
- Reset, game_enable=1, btn low → ARMED, then READY; turn_cat=1, turn_dog=0, throw_command=0.
- Hold btn for 40 cycles, then release → throw_command high for 40 cycles; throw_power=10 and holds 10 afterwards.
- Hold btn for 1100 cycles → power climbs to 255, then reads 254 on the next step; no wrap ever observed.
- In RELEASE with cat active: a throw_complete_dog pulse is ignored; a throw_complete_cat pulse → SWITCH, then turn_dog=1 two cycles later and power=0.
- No complete pulse → SWITCH after exactly 1000 RELEASE cycles. Button held through SWITCH → stays in ARMED until it is released.
- With THROW_CTRL_POWER_BAR_EN and power=10: pixel (BAR_X+9, BAR_Y) is BAR_RGB, (BAR_X+10, BAR_Y) is BAR_BG_RGB, and (BAR_X+256, BAR_Y) passes through. The output lags the input by 1 cycle.

Source files
------------

// File: rtl/game_pkg.sv
// Shared types and constants for the cat-vs-dog game control path.
package game_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARMED   = 3'd1,
        READY   = 3'd2,
        CHARGE  = 3'd3,
        RELEASE = 3'd4,
        SWITCH  = 3'd5
    } state_t;

    localparam logic       PLAYER_CAT = 1'b0;
    localparam logic       PLAYER_DOG = 1'b1;
    localparam logic [7:0] MAX_POWER  = 8'd255;

endpackage

// File: rtl/throw_power_ramp.sv
// Throw power generator: a prescaler sets the step rate and the power value
// bounces between 0 and MAX_POWER instead of wrapping.
module throw_power_ramp
    import game_pkg::*;
#(
    parameter int unsigned STEP_CYCLES = 65_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       enable,
    output logic [7:0] power
);

    localparam int unsigned PW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(STEP_CYCLES - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic [7:0]    power_q, power_d;
    logic          up_q, up_d;

    // Next-state for prescaler, power and ramp direction.
    always_comb begin
        presc_d = presc_q;
        power_d = power_q;
        up_d    = up_q;
        if (clear) begin
            presc_d = '0;
            power_d = 8'd0;
            up_d    = 1'b1;
        end else if (enable) begin
            if (presc_q == PRESC_LAST) begin
                presc_d = '0;
                if (up_q) begin
                    if (power_q == MAX_POWER) begin
                        power_d = MAX_POWER - 8'd1;
                        up_d    = 1'b0;
                    end else begin
                        power_d = power_q + 8'd1;
                    end
                end else begin
                    if (power_q == 8'd0) begin
                        power_d = 8'd1;
                        up_d    = 1'b1;
                    end else begin
                        power_d = power_q - 8'd1;
                    end
                end
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end
    end

    // Ramp registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q <= '0;
            power_q <= 8'd0;
            up_q    <= 1'b1;
        end else begin
            presc_q <= presc_d;
            power_q <= power_d;
            up_q    <= up_d;
        end
    end

    assign power = power_q;

endmodule

// File: rtl/throw_ctrl.sv
// Turn and throw initiator plus a one-stage VGA overlay.
// Optional power bar overlay: define THROW_CTRL_POWER_BAR_EN.
//
// state   | meaning
// IDLE    | game disabled or in reset
// ARMED   | turn owned, waiting for the button to be released
// READY   | waiting for a button press
// CHARGE  | throw requested, power ramping
// RELEASE | power frozen, waiting for the drawer to finish
// SWITCH  | hand the turn to the other player
module throw_ctrl
    import game_pkg::*;
#(
    parameter int unsigned POWER_STEP_CYCLES = 65_000,
    parameter int unsigned TIMEOUT_CYCLES    = 8_000_000,
    parameter int unsigned BAR_X             = 384,
    parameter int unsigned BAR_Y             = 40,
    parameter int unsigned BAR_H             = 16,
    parameter logic [11:0] BAR_RGB           = 12'hF40,
    parameter logic [11:0] BAR_BG_RGB        = 12'h333
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        game_enable,
    input  logic        btn_throw,
    input  logic        throw_complete_cat,
    input  logic        throw_complete_dog,
    output logic        turn_cat,
    output logic        turn_dog,
    output logic        throw_command,
    output logic [7:0]  throw_power,
    output logic [2:0]  ctrl_state,
    input  logic [10:0] vga_in_hcount,
    input  logic [10:0] vga_in_vcount,
    input  logic        vga_in_hsync,
    input  logic        vga_in_vsync,
    input  logic        vga_in_hblnk,
    input  logic        vga_in_vblnk,
    input  logic [11:0] vga_in_rgb,
    output logic [10:0] vga_out_hcount,
    output logic [10:0] vga_out_vcount,
    output logic        vga_out_hsync,
    output logic        vga_out_vsync,
    output logic        vga_out_hblnk,
    output logic        vga_out_vblnk,
    output logic [11:0] vga_out_rgb
);

    localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT_CYCLES - 1);

    state_t        state_q, state_d;
    logic          turn_sel_q, turn_sel_d;
    logic [TW-1:0] wait_q, wait_d;
    logic          cmd_q, cmd_d;
    logic          turn_cat_q, turn_cat_d;
    logic          turn_dog_q, turn_dog_d;
    logic          complete_active;
    logic          ramp_clear, ramp_enable;
    logic [7:0]    power_w;
    logic          turn_owned;

    assign complete_active = (turn_sel_q == PLAYER_DOG) ? throw_complete_dog : throw_complete_cat;

    // Next-state, timeout counter and registered-output decode.
    always_comb begin
        state_d    = state_q;
        turn_sel_d = turn_sel_q;
        wait_d     = '0;
        if (!game_enable) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    state_d = ARMED;
                ARMED:   if (!btn_throw) state_d = READY;
                READY:   if (btn_throw) state_d = CHARGE;
                CHARGE:  if (!btn_throw) state_d = RELEASE;
                RELEASE: begin
                    wait_d = wait_q + TW'(1);
                    if (complete_active || (wait_q == WAIT_LAST)) state_d = SWITCH;
                end
                SWITCH:  state_d = ARMED;
                default: state_d = IDLE;
            endcase
        end
        if (state_q == SWITCH) turn_sel_d = ~turn_sel_q;
        turn_owned = (state_d == ARMED) || (state_d == READY) ||
                     (state_d == CHARGE) || (state_d == RELEASE);
        cmd_d      = (state_d == CHARGE);
        turn_cat_d = turn_owned && (turn_sel_d == PLAYER_CAT);
        turn_dog_d = turn_owned && (turn_sel_d == PLAYER_DOG);
    end

    // Control registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            turn_sel_q <= PLAYER_CAT;
            wait_q     <= '0;
            cmd_q      <= 1'b0;
            turn_cat_q <= 1'b0;
            turn_dog_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            turn_sel_q <= turn_sel_d;
            wait_q     <= wait_d;
            cmd_q      <= cmd_d;
            turn_cat_q <= turn_cat_d;
            turn_dog_q <= turn_dog_d;
        end
    end

    // Stepping stops on the release edge itself so a simultaneous wrap is dropped.
    assign ramp_enable = (state_q == CHARGE) && btn_throw && game_enable;
    assign ramp_clear  = (state_d == IDLE) || (state_q == SWITCH) ||
                         ((state_q == READY) && (state_d == CHARGE));

    throw_power_ramp #(
        .STEP_CYCLES(POWER_STEP_CYCLES)
    ) u_ramp (
        .clk    (clk),
        .rst    (rst),
        .clear  (ramp_clear),
        .enable (ramp_enable),
        .power  (power_w)
    );

    assign turn_cat      = turn_cat_q;
    assign turn_dog      = turn_dog_q;
    assign throw_command = cmd_q;
    assign throw_power   = power_w;
    assign ctrl_state    = state_q;

    logic [10:0] hcount_q, vcount_q;
    logic        hsync_q, vsync_q, hblnk_q, vblnk_q;
    logic [11:0] rgb_q;

    // One register stage for the whole VGA stream.
    always_ff @(posedge clk) begin
        if (rst) begin
            hcount_q <= '0;
            vcount_q <= '0;
            hsync_q  <= 1'b0;
            vsync_q  <= 1'b0;
            hblnk_q  <= 1'b0;
            vblnk_q  <= 1'b0;
            rgb_q    <= '0;
        end else begin
            hcount_q <= vga_in_hcount;
            vcount_q <= vga_in_vcount;
            hsync_q  <= vga_in_hsync;
            vsync_q  <= vga_in_vsync;
            hblnk_q  <= vga_in_hblnk;
            vblnk_q  <= vga_in_vblnk;
            rgb_q    <= vga_in_rgb;
        end
    end

    assign vga_out_hcount = hcount_q;
    assign vga_out_vcount = vcount_q;
    assign vga_out_hsync  = hsync_q;
    assign vga_out_vsync  = vsync_q;
    assign vga_out_hblnk  = hblnk_q;
    assign vga_out_vblnk  = vblnk_q;

`ifdef THROW_CTRL_POWER_BAR_EN
    localparam logic [10:0] BAR_X_L   = 11'(BAR_X);
    localparam logic [10:0] BAR_X_END = 11'(BAR_X + 256);
    localparam logic [10:0] BAR_Y_L   = 11'(BAR_Y);
    localparam logic [10:0] BAR_Y_END = 11'(BAR_Y + BAR_H);

    logic [10:0] bar_dx;
    logic        in_bar;

    // Overlay decided from the already-delayed pixel so latency is unchanged.
    always_comb begin
        bar_dx = hcount_q - BAR_X_L;
        in_bar = ((state_q == CHARGE) || (state_q == RELEASE)) &&
                 (hcount_q >= BAR_X_L) && (hcount_q < BAR_X_END) &&
                 (vcount_q >= BAR_Y_L) && (vcount_q < BAR_Y_END) &&
                 !hblnk_q && !vblnk_q;
        vga_out_rgb = rgb_q;
        if (in_bar) vga_out_rgb = (bar_dx < {3'b000, power_w}) ? BAR_RGB : BAR_BG_RGB;
    end
`else
    assign vga_out_rgb = rgb_q;
`endif

endmodule

// File: tb/tb_throw_ctrl.sv
// Directed bench for throw_ctrl with a short power step and timeout.
module tb_throw_ctrl;

    localparam int BAR_X = 384;
    localparam int BAR_Y = 40;

    logic        clk = 1'b0;
    logic        rst;
    logic        game_enable, btn_throw, tc_cat, tc_dog;
    logic        turn_cat, turn_dog, throw_command;
    logic [7:0]  throw_power;
    logic [2:0]  ctrl_state;
    logic [10:0] hin, vin, hout, vout;
    logic        hsi, vsi, hbi, vbi, hso, vso, hbo, vbo;
    logic [11:0] rgbi, rgbo;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    throw_ctrl #(
        .POWER_STEP_CYCLES(4),
        .TIMEOUT_CYCLES   (1000)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .game_enable       (game_enable),
        .btn_throw         (btn_throw),
        .throw_complete_cat(tc_cat),
        .throw_complete_dog(tc_dog),
        .turn_cat          (turn_cat),
        .turn_dog          (turn_dog),
        .throw_command     (throw_command),
        .throw_power       (throw_power),
        .ctrl_state        (ctrl_state),
        .vga_in_hcount     (hin),
        .vga_in_vcount     (vin),
        .vga_in_hsync      (hsi),
        .vga_in_vsync      (vsi),
        .vga_in_hblnk      (hbi),
        .vga_in_vblnk      (vbi),
        .vga_in_rgb        (rgbi),
        .vga_out_hcount    (hout),
        .vga_out_vcount    (vout),
        .vga_out_hsync     (hso),
        .vga_out_vsync     (vso),
        .vga_out_hblnk     (hbo),
        .vga_out_vblnk     (vbo),
        .vga_out_rgb       (rgbo)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; game_enable = 1'b1; btn_throw = 1'b0; tc_cat = 1'b0; tc_dog = 1'b0;
        hin = 11'd5; vin = 11'd6; hsi = 1'b1; vsi = 1'b1; hbi = 1'b1; vbi = 1'b1; rgbi = 12'hFFF;
        step(); step();
        checks++;
        if ({turn_cat, turn_dog, throw_command, throw_power, ctrl_state} !== 14'd0) begin
            errors++;
            $display("FAIL reset_ctrl: got cat=%0b dog=%0b cmd=%0b pwr=%0d st=%0d, want all 0",
                     turn_cat, turn_dog, throw_command, throw_power, ctrl_state);
        end
        checks++;
        if ({hout, vout, hso, vso, hbo, vbo, rgbo} !== 38'd0) begin
            errors++;
            $display("FAIL reset_vga: got h=%0d v=%0d rgb=%h, want 0", hout, vout, rgbo);
        end
        hin = '0; vin = '0; hsi = 1'b0; vsi = 1'b0; hbi = 1'b0; vbi = 1'b0; rgbi = '0;
        rst = 1'b0;
    endtask

    task automatic test_arm();
        step();
        checks++;
        if (ctrl_state !== 3'd1 || turn_cat !== 1'b1 || turn_dog !== 1'b0) begin
            errors++;
            $display("FAIL arm_armed: got st=%0d cat=%0b dog=%0b, want 1 1 0", ctrl_state, turn_cat, turn_dog);
        end
        step();
        checks++;
        if (ctrl_state !== 3'd2 || throw_command !== 1'b0 || turn_cat !== 1'b1) begin
            errors++;
            $display("FAIL arm_ready: got st=%0d cmd=%0b cat=%0b, want 2 0 1", ctrl_state, throw_command, turn_cat);
        end
    endtask

    task automatic test_charge_40();
        int low_seen = 0;
        btn_throw = 1'b1;
        step();
        checks++;
        if (ctrl_state !== 3'd3 || throw_command !== 1'b1 || throw_power !== 8'd0) begin
            errors++;
            $display("FAIL charge_start: got st=%0d cmd=%0b pwr=%0d, want 3 1 0", ctrl_state, throw_command, throw_power);
        end
        for (int i = 0; i < 40; i++) begin
            step();
            if (throw_command !== 1'b1) low_seen++;
        end
        checks++;
        if (low_seen != 0 || throw_power !== 8'd10) begin
            errors++;
            $display("FAIL charge_40: got cmd_low=%0d pwr=%0d, want 0 10", low_seen, throw_power);
        end
        btn_throw = 1'b0;
        step();
        checks++;
        if (ctrl_state !== 3'd4 || throw_command !== 1'b0 || throw_power !== 8'd10) begin
            errors++;
            $display("FAIL release: got st=%0d cmd=%0b pwr=%0d, want 4 0 10", ctrl_state, throw_command, throw_power);
        end
        repeat (5) step();
        checks++;
        if (throw_power !== 8'd10) begin
            errors++;
            $display("FAIL power_hold: got %0d want 10", throw_power);
        end
    endtask

    task automatic test_vga();
        logic [11:0] exp_a, exp_b;
`ifdef THROW_CTRL_POWER_BAR_EN
        exp_a = 12'hF40; exp_b = 12'h333;
`else
        exp_a = 12'hABC; exp_b = 12'hABC;
`endif
        hin = 11'(BAR_X + 9); vin = 11'(BAR_Y); rgbi = 12'hABC; hsi = 1'b1; vsi = 1'b0;
        step();
        checks++;
        if (hout !== 11'(BAR_X + 9) || vout !== 11'(BAR_Y) || hso !== 1'b1 || rgbo !== exp_a) begin
            errors++;
            $display("FAIL vga_fill: got h=%0d v=%0d hs=%0b rgb=%h, want %0d %0d 1 %h",
                     hout, vout, hso, rgbo, BAR_X + 9, BAR_Y, exp_a);
        end
        hin = 11'(BAR_X + 10); hsi = 1'b0; vsi = 1'b1;
        #1;
        checks++;
        if (hout !== 11'(BAR_X + 9) || hso !== 1'b1) begin
            errors++;
            $display("FAIL vga_latency: got h=%0d hs=%0b before edge, want %0d 1", hout, hso, BAR_X + 9);
        end
        step();
        checks++;
        if (hout !== 11'(BAR_X + 10) || vso !== 1'b1 || rgbo !== exp_b) begin
            errors++;
            $display("FAIL vga_bg: got h=%0d vs=%0b rgb=%h, want %0d 1 %h", hout, vso, rgbo, BAR_X + 10, exp_b);
        end
        hin = 11'(BAR_X + 256);
        step();
        checks++;
        if (rgbo !== 12'hABC) begin
            errors++;
            $display("FAIL vga_outside: got rgb=%h want abc", rgbo);
        end
        hin = 11'(BAR_X + 9); hbi = 1'b1; vbi = 1'b1; rgbi = 12'h123;
        step();
        checks++;
        if (rgbo !== 12'h123 || hbo !== 1'b1 || vbo !== 1'b1) begin
            errors++;
            $display("FAIL vga_blank: got rgb=%h hb=%0b vb=%0b, want 123 1 1", rgbo, hbo, vbo);
        end
        hin = '0; vin = '0; hsi = 1'b0; vsi = 1'b0; hbi = 1'b0; vbi = 1'b0; rgbi = '0;
    endtask

    task automatic test_complete();
        tc_dog = 1'b1;
        step();
        tc_dog = 1'b0;
        checks++;
        if (ctrl_state !== 3'd4) begin
            errors++;
            $display("FAIL ignore_dog: got st=%0d want 4", ctrl_state);
        end
        tc_cat = 1'b1;
        step();
        tc_cat = 1'b0;
        checks++;
        if (ctrl_state !== 3'd5 || turn_dog !== 1'b0) begin
            errors++;
            $display("FAIL switch: got st=%0d dog=%0b want 5 0", ctrl_state, turn_dog);
        end
        step();
        checks++;
        if (ctrl_state !== 3'd1 || turn_dog !== 1'b1 || turn_cat !== 1'b0 || throw_power !== 8'd0) begin
            errors++;
            $display("FAIL new_turn: got st=%0d dog=%0b cat=%0b pwr=%0d, want 1 1 0 0",
                     ctrl_state, turn_dog, turn_cat, throw_power);
        end
    endtask

    task automatic test_release_wins();
        step();
        btn_throw = 1'b1;
        step();
        repeat (39) step();
        btn_throw = 1'b0;
        step();
        checks++;
        if (ctrl_state !== 3'd4 || throw_power !== 8'd9) begin
            errors++;
            $display("FAIL release_wins: got st=%0d pwr=%0d want 4 9", ctrl_state, throw_power);
        end
    endtask

    task automatic test_timeout();
        int cnt = 1;
        tc_cat = 1'b1;
        step();
        tc_cat = 1'b0;
        if (ctrl_state === 3'd4) cnt++;
        while (ctrl_state === 3'd4 && cnt < 2000) begin
            step();
            if (ctrl_state === 3'd4) cnt++;
        end
        checks++;
        if (cnt != 1000 || ctrl_state !== 3'd5) begin
            errors++;
            $display("FAIL timeout: got %0d release cycles then st=%0d, want 1000 then 5", cnt, ctrl_state);
        end
        btn_throw = 1'b1;
        repeat (6) step();
        checks++;
        if (ctrl_state !== 3'd1 || turn_cat !== 1'b1 || turn_dog !== 1'b0) begin
            errors++;
            $display("FAIL held_btn: got st=%0d cat=%0b dog=%0b want 1 1 0", ctrl_state, turn_cat, turn_dog);
        end
        btn_throw = 1'b0;
        step();
        checks++;
        if (ctrl_state !== 3'd2) begin
            errors++;
            $display("FAIL held_release: got st=%0d want 2", ctrl_state);
        end
    endtask

    task automatic test_pingpong();
        int bad = 0;
        int prev = 0;
        bit seen_top = 0;
        bit seen_turn = 0;
        btn_throw = 1'b1;
        step();
        for (int i = 0; i < 1100; i++) begin
            step();
            if (int'(throw_power) - prev > 1 || prev - int'(throw_power) > 1) bad++;
            if (throw_power == 8'd255) seen_top = 1;
            if (seen_top && throw_power == 8'd254) seen_turn = 1;
            prev = int'(throw_power);
        end
        checks++;
        if (bad != 0 || !seen_top || !seen_turn || throw_power !== 8'd235) begin
            errors++;
            $display("FAIL pingpong: got jumps=%0d top=%0b turn=%0b pwr=%0d, want 0 1 1 235",
                     bad, seen_top, seen_turn, throw_power);
        end
        btn_throw = 1'b0;
        step();
    endtask

    task automatic test_enable_drop();
        game_enable = 1'b0;
        step();
        checks++;
        if (ctrl_state !== 3'd0 || throw_command !== 1'b0 || throw_power !== 8'd0 || turn_cat !== 1'b0) begin
            errors++;
            $display("FAIL drop_release: got st=%0d cmd=%0b pwr=%0d cat=%0b want 0 0 0 0",
                     ctrl_state, throw_command, throw_power, turn_cat);
        end
        game_enable = 1'b1;
        step();
        checks++;
        if (ctrl_state !== 3'd1 || turn_cat !== 1'b1 || turn_dog !== 1'b0) begin
            errors++;
            $display("FAIL turn_kept: got st=%0d cat=%0b dog=%0b want 1 1 0", ctrl_state, turn_cat, turn_dog);
        end
        step();
        btn_throw = 1'b1;
        step();
        repeat (10) step();
        game_enable = 1'b0;
        step();
        checks++;
        if (ctrl_state !== 3'd0 || throw_command !== 1'b0 || throw_power !== 8'd0) begin
            errors++;
            $display("FAIL drop_charge: got st=%0d cmd=%0b pwr=%0d want 0 0 0", ctrl_state, throw_command, throw_power);
        end
        btn_throw = 1'b0;
    endtask

    initial begin
        test_reset();
        test_arm();
        test_charge_40();
        test_vga();
        test_complete();
        test_release_wins();
        test_timeout();
        test_pingpong();
        test_enable_drop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
